// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch vs. data requester, one outstanding
// transaction, response routing, stall generation and flush kill.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_sel,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_sel,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       kill_q, kill_d;
  logic [3:0] run_q, run_d;
  logic       fetch_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      kill_q  <= 1'b0;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      run_q   <= run_d;
    end
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    kill_d   = kill_q;
    run_d    = run_q;
    m_req    = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    // data has priority unless the fetch has waited out a full data run
    fetch_win = i_req & (~d_req | (run_q == RUN_MAX));
    m_we    = ~fetch_win & d_we;
    m_addr  = fetch_win ? i_addr : d_addr;
    m_wdata = d_wdata;
    m_sel   = fetch_win ? '1 : d_sel;

    unique case (state_q)
      IDLE: begin
        m_req = i_req | d_req;
        if (m_req & m_gnt) begin
          i_gnt   = fetch_win;
          d_gnt   = ~fetch_win;
          owner_d = ~fetch_win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush & ~owner_q) kill_d = 1'b1;
        if (m_rvalid) begin
          i_rvalid = ~owner_q & ~kill_q & ~flush;
          d_rvalid = owner_q;
          state_d  = IDLE;
          kill_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_req || i_gnt) begin
      run_d = 4'd0;
    end else if (d_gnt && run_q != RUN_MAX) begin
      run_d = run_q + 4'd1;
    end

    if (!rst_n) begin
      m_req    = 1'b0;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end

    stall_if  = rst_n & ((i_req & ~i_gnt) |
                ((state_q == BUSY) & ~owner_q & ~i_rvalid));
    stall_mem = rst_n & ((d_req & ~d_gnt) |
                ((state_q == BUSY) & owner_q & ~d_rvalid));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, starvation sequence
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX_RUN = 4;

  typedef struct packed {
    bit rst_n, flush, i_req, d_req, d_we, m_gnt, m_rvalid;
    bit mreq, ig, dg, irv, drv, sif, smem, wf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, i_req, d_req, d_we, m_gnt, m_rvalid;
  logic [63:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [7:0]  d_sel;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [63:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        m_req, m_we, stall_if, stall_mem;
  logic [7:0]  m_sel;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit mb_busy, mb_data, mb_drop;
  int mb_streak;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MAX_DATA_RUN(MAX_RUN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_sel(d_sel), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_sel(m_sel), .m_gnt(m_gnt),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit [6:0] in, input bit [7:0] ex);
    vec_t v;
    {v.rst_n, v.flush, v.i_req, v.d_req, v.d_we, v.m_gnt, v.m_rvalid} = in;
    {v.mreq, v.ig, v.dg, v.irv, v.drv, v.sif, v.smem, v.wf} = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n    = v.rst_n;
    flush    = v.flush;
    i_req    = v.i_req;
    d_req    = v.d_req;
    d_we     = v.d_we;
    m_gnt    = v.m_gnt;
    m_rvalid = v.m_rvalid;
  endtask

  // One clock: model expectation, comparison, then model advance.
  task automatic run_cycle(input bit use_tbl, input vec_t v,
                           output bit gi, output bit gd,
                           output bit a_ig, output bit a_dg);
    bit xm, xig, xdg, xirv, xdrv, xsif, xsm, xwf, fw;
    xm = 0; xig = 0; xdg = 0; xirv = 0; xdrv = 0;
    xsif = 0; xsm = 0; xwf = 0;
    #4;
    if (rst_n) begin
      if (!mb_busy) begin
        fw  = i_req && (!d_req || mb_streak >= MAX_RUN);
        xm  = i_req || d_req;
        xwf = fw;
        if (xm && m_gnt) begin
          xig = fw;
          xdg = !fw;
        end
      end else if (m_rvalid) begin
        if (mb_data) xdrv = 1;
        else if (!mb_drop && !flush) xirv = 1;
      end
      xsif = (i_req && !xig) || (mb_busy && !mb_data && !xirv);
      xsm  = (d_req && !xdg) || (mb_busy && mb_data && !xdrv);
    end
    gi = xig;
    gd = xdg;
    if (use_tbl) begin
      xm = v.mreq; xig = v.ig; xdg = v.dg; xirv = v.irv;
      xdrv = v.drv; xsif = v.sif; xsm = v.smem; xwf = v.wf;
    end
    a_ig = i_gnt;
    a_dg = d_gnt;
    chk("m_req", m_req, xm);
    chk("i_gnt", i_gnt, xig);
    chk("d_gnt", d_gnt, xdg);
    chk("i_rvalid", i_rvalid, xirv);
    chk("d_rvalid", d_rvalid, xdrv);
    chk("stall_if", stall_if, xsif);
    chk("stall_mem", stall_mem, xsm);
    if (xm) begin
      chk("m_addr", m_addr, xwf ? i_addr : d_addr);
      chk("m_sel", m_sel, xwf ? 64'hFF : 64'(d_sel));
      chk("m_we", m_we, xwf ? 1'b0 : d_we);
      if (!xwf) chk("m_wdata", m_wdata, d_wdata);
    end
    if (xirv) chk("i_rdata", i_rdata, m_rdata);
    if (xdrv) chk("d_rdata", d_rdata, m_rdata);
    @(posedge clk);
    if (!rst_n) begin
      mb_busy = 0; mb_data = 0; mb_drop = 0; mb_streak = 0;
    end else begin
      if (!mb_busy) begin
        if (gi || gd) begin
          mb_busy = 1;
          mb_data = gd;
        end
      end else begin
        if (!mb_data && flush) mb_drop = 1;
        if (m_rvalid) begin
          mb_busy = 0;
          mb_drop = 0;
        end
      end
      if (!i_req || gi) mb_streak = 0;
      else if (gd && mb_streak < MAX_RUN) mb_streak++;
    end
    cyc++;
    #1;
  endtask

  vec_t tbl[$];
  vec_t nv;
  bit gi, gd, aig, adg;
  bit ipend, dpend;
  int gcount;

  initial begin
    nv = mk(7'b0, 8'b0);
    mb_busy = 0; mb_data = 0; mb_drop = 0; mb_streak = 0;
    drive(nv);
    i_addr  = 64'h8000_0000;
    d_addr  = 64'h0000_1000;
    d_wdata = 64'hCAFE_F00D_DEAD_BEEF;
    d_sel   = 8'hF0;
    m_rdata = 64'h1122_3344_5566_7788;
    @(posedge clk);
    #1;

    // in : rst_n flush i_req d_req d_we m_gnt m_rvalid
    // out: mreq ig dg irv drv sif smem wf
    tbl.push_back(mk(7'b0_0_0_0_0_0_0, 8'b0000_0000));
    tbl.push_back(mk(7'b0_0_1_1_0_1_1, 8'b0000_0000));
    // lone fetch
    tbl.push_back(mk(7'b1_0_1_0_0_1_0, 8'b1100_0001));
    tbl.push_back(mk(7'b1_0_0_0_0_0_0, 8'b0000_0100));
    tbl.push_back(mk(7'b1_0_0_0_0_0_1, 8'b0001_0000));
    tbl.push_back(mk(7'b1_0_0_0_0_0_0, 8'b0000_0000));
    // conflict
    tbl.push_back(mk(7'b1_0_1_1_0_1_0, 8'b1010_0100));
    tbl.push_back(mk(7'b1_0_1_0_0_1_0, 8'b0000_0110));
    tbl.push_back(mk(7'b1_0_1_0_0_1_1, 8'b0000_1100));
    tbl.push_back(mk(7'b1_0_1_0_0_1_0, 8'b1100_0001));
    tbl.push_back(mk(7'b1_0_0_0_0_0_1, 8'b0001_0000));
    // memory not accepting, then accepted; flush kill
    tbl.push_back(mk(7'b1_0_1_0_0_0_0, 8'b1000_0101));
    tbl.push_back(mk(7'b1_0_1_0_0_1_0, 8'b1100_0001));
    tbl.push_back(mk(7'b1_1_0_0_0_0_0, 8'b0000_0100));
    tbl.push_back(mk(7'b1_0_0_0_0_0_0, 8'b0000_0100));
    tbl.push_back(mk(7'b1_0_0_0_0_0_1, 8'b0000_0100));
    tbl.push_back(mk(7'b1_0_0_1_0_1_0, 8'b1010_0000));
    tbl.push_back(mk(7'b1_0_0_0_0_0_1, 8'b0000_1000));
    // flush coincident with fetch response
    tbl.push_back(mk(7'b1_0_1_0_0_1_0, 8'b1100_0001));
    tbl.push_back(mk(7'b1_1_0_0_0_0_1, 8'b0000_0100));
    // store under flush
    tbl.push_back(mk(7'b1_0_0_1_1_1_0, 8'b1010_0000));
    tbl.push_back(mk(7'b1_1_0_0_0_0_0, 8'b0000_0010));
    tbl.push_back(mk(7'b1_1_0_0_0_0_1, 8'b0000_1000));
    // stray response in IDLE
    tbl.push_back(mk(7'b1_0_0_0_0_0_1, 8'b0000_0000));
    // reset during outstanding load
    tbl.push_back(mk(7'b1_0_0_1_0_1_0, 8'b1010_0000));
    tbl.push_back(mk(7'b1_0_0_0_0_0_0, 8'b0000_0010));
    tbl.push_back(mk(7'b0_0_1_1_0_1_1, 8'b0000_0000));
    tbl.push_back(mk(7'b1_0_0_0_0_0_1, 8'b0000_0000));
    tbl.push_back(mk(7'b1_0_0_0_0_0_0, 8'b0000_0000));

    foreach (tbl[k]) begin
      drive(tbl[k]);
      run_cycle(1'b1, tbl[k], gi, gd, aig, adg);
    end

    // starvation guard: both requesters held, 1-cycle memory latency
    gcount = 0;
    for (int j = 0; j < 20; j++) begin
      nv = mk({6'b1_0_1_1_0_1, 1'(j % 2)}, 8'b0);
      drive(nv);
      run_cycle(1'b0, nv, gi, gd, aig, adg);
      if (j % 2 == 0) begin
        chk("starve_i_gnt", 64'(aig), 64'(gcount % 5 == 4));
        chk("starve_d_gnt", 64'(adg), 64'(gcount % 5 != 4));
        gcount++;
      end
    end
    nv = mk(7'b1_0_0_0_0_0_1, 8'b0);
    drive(nv);
    run_cycle(1'b0, nv, gi, gd, aig, adg);

    // randomized traffic; requests held until the model grants them
    ipend = 0;
    dpend = 0;
    for (int j = 0; j < 600; j++) begin
      if (!ipend && $urandom_range(2) == 0) begin
        ipend  = 1;
        i_addr = {$urandom, $urandom};
      end
      if (!dpend && $urandom_range(2) == 0) begin
        dpend   = 1;
        d_addr  = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        d_sel   = 8'($urandom);
        d_we    = 1'($urandom);
      end
      rst_n    = ($urandom_range(39) != 0);
      flush    = ($urandom_range(9) == 0);
      m_gnt    = ($urandom_range(3) != 0);
      m_rvalid = ($urandom_range(4) < 2);
      m_rdata  = {$urandom, $urandom};
      i_req    = ipend;
      d_req    = dpend;
      run_cycle(1'b0, nv, gi, gd, aig, adg);
      if (gi) ipend = 0;
      if (gd) dpend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the core's single shared 64-bit memory port. The instruction-fetch requester and the data (MEM1 load/store) requester compete for the port. The block selects a winner, tracks the single outstanding transaction and routes the response back to its owner, which feeds MEM2's load-alignment path. It also produces stall requests for the pipeline stall controller, and drops stale fetch responses after a pipeline flush.

## Interface
- ADDR_W, 64, address width of all ports
- DATA_W, 64, data width; byte-select width is DATA_W/8
- MAX_DATA_RUN, 4, consecutive data grants allowed while a fetch waits (range 1..15)

- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush; kills an in-flight fetch response
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch response valid
- i_rdata  out  DATA_W  fetch response data (equals m_rdata)
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_sel  in  DATA_W/8  byte selects
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (load data or store ack) valid
- d_rdata  out  DATA_W  load data (equals m_rdata)
- m_req, m_we, m_addr, m_wdata, m_sel  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request, muxed from the winner
- m_gnt  in  1  memory accepts the request this cycle
- m_rvalid  in  1  memory response valid
- m_rdata  in  DATA_W  memory response data
- stall_if  out  1  fetch must stall
- stall_mem  out  1  data stage must stall

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction granted and awaiting m_rvalid.
- Registers:
  - owner (0 = fetch, 1 = data)
  - kill (drop the fetch response)
  - run_cnt, 4 bits
- Winner selection in IDLE, combinational:
  - Data wins over fetch.
  - Exception: when i_req=1 and run_cnt==MAX_DATA_RUN, fetch wins.
- In IDLE, m_req = i_req|d_req, and the winner's payload drives m_*. For a fetch, m_we=0 and m_sel is all ones.
- On m_req & m_gnt in IDLE:
  - Assert the winner's gnt in the same cycle.
  - Latch owner and go to BUSY.
  - A data grant with i_req=1 increments run_cnt.
  - A fetch grant, or any cycle with i_req=0, clears run_cnt.
- In BUSY:
  - m_req=0 and both gnts are 0.
  - On m_rvalid, assert the owner's rvalid for that cycle and return to IDLE. The next grant is possible one cycle later.
  - Exception: a fetch response with kill=1 asserts no rvalid.
- Flush:
  - Flush in BUSY with owner=fetch sets kill.
  - Flush never affects data transactions; stores always complete.
  - kill clears when leaving BUSY.
- m_rvalid in IDLE is ignored.
- Stall outputs, combinational:
  - stall_if = i_req & ~i_gnt, or (BUSY & owner=fetch & ~i_rvalid).
  - stall_mem = d_req & ~d_gnt, or (BUSY & owner=data & ~d_rvalid).

## Timing
- Reset values:
  - state=IDLE, owner=0, kill=0, run_cnt=0.
  - While rst_n=0, all outputs (m_req, gnts, rvalids, stalls) are forced 0.
- Reset mid-transaction abandons it; a subsequent stray m_rvalid is ignored in IDLE.
- Grant is combinational off m_gnt (zero-cycle accept). Response earliest 1 cycle after grant.
- Minimum turnaround: grant at cycle t, response at t+1, next grant at t+2.
- Simultaneous flush and m_rvalid for a fetch in BUSY: the response is dropped (i_rvalid=0).
- Simultaneous i_req and d_req with run_cnt<MAX_DATA_RUN: d_gnt.
- run_cnt saturates at MAX_DATA_RUN; it never wraps.

## Test plan
- Lone fetch: i_req=1, i_addr=0x80000000, m_gnt=1 at t0, m_rvalid=1 with m_rdata=0x1122334455667788 at t2.
  - Required: i_gnt at t0; i_rvalid with that data at t2; stall_if high at t1, low at t2.
- Conflict: i_req=d_req=1 at t0, d_we=0.
  - Required: d_gnt at t0, i_gnt=0, m_addr=d_addr; fetch granted on the first IDLE cycle after the data response.
- Starvation guard, MAX_DATA_RUN=4: d_req and i_req held continuously, 1-cycle memory latency.
  - Required: 4 data grants, then 1 fetch grant, repeating.
- Flush kill: fetch granted at t0, flush at t1, m_rvalid at t3.
  - Required: i_rvalid=0 at t3; state IDLE at t4.
- Store under flush: d_we=1, d_sel=0xF0 granted, flush next cycle.
  - Required: d_rvalid still asserted on m_rvalid; m_sel=0xF0 at grant.
- Reset mid-BUSY: rst_n=0 one cycle during an outstanding load, then m_rvalid=1.
  - Required: outputs 0 during reset; no d_rvalid afterward.
